csr_access_unit: RTL

Sequential CSR access engine between the decode/execute stage and the machine/supervisor scratch-register file. Accepts one CSR instruction at a time (CSRRW/CSRRS/CSRRC semantics) and checks address, privilege and read-only rules. Reads the current scratch value, then drives the file's write port (`csr_write`, `data_csr`, one-hot selects) with the read-modify-write result. Returns the pre-write value to the pipeline over a valid/ready response channel.

---
 rtl/csr_pkg.sv | 32 +++
 rtl/csr_addr_decode.sv | 26 ++
 rtl/csr_access_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared constants and types for the CSR access engine and its address decoder.
package csr_pkg;

  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_SSCRATCH = 12'h140;

  typedef enum logic [1:0] {
    OP_RSVD = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic m;
    logic s;
  } csr_sel_t;

endpackage

// File: rtl/csr_addr_decode.sv
// Combinational CSR address/privilege/read-only check producing a one-hot select.
module csr_addr_decode
  import csr_pkg::*;
(
  input  logic [11:0] addr,
  input  logic [1:0]  op,
  input  logic [1:0]  priv,
  input  logic        no_write,
  output csr_sel_t    sel,
  output logic        illegal
);

  logic writes;

  always_comb begin
    sel.m   = (addr == CSR_MSCRATCH);
    sel.s   = (addr == CSR_SSCRATCH);
    // RW always writes; RS/RC write only when the operand field is non-zero
    writes  = (op == OP_RW) || !no_write;
    illegal = (op == OP_RSVD)
           || !(sel.m || sel.s)
           || (priv < addr[9:8])
           || ((addr[11:10] == 2'b11) && writes);
  end

endmodule

// File: rtl/csr_access_unit.sv
// Sequential read-modify-write engine for the machine/supervisor scratch CSRs.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [11:0]     req_addr,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            req_no_write,
  input  logic [1:0]      req_priv,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic [XLEN-1:0] mscratch,
  input  logic [XLEN-1:0] sscratch,
  output logic            csr_write,
  output logic [XLEN-1:0] data_csr,
  output logic            mrw_mscratch_sel,
  output logic            srw_sscratch_sel
);

  state_e          state, state_nxt;
  csr_sel_t        dec_sel, sel_q;
  logic            dec_illegal;
  logic [1:0]      op_q;
  logic [XLEN-1:0] wdata_q, new_q, rdata_q, old_val;
  logic            no_write_q, illegal_q, suppress;

  csr_addr_decode u_decode (
    .addr     (req_addr),
    .op       (req_op),
    .priv     (req_priv),
    .no_write (req_no_write),
    .sel      (dec_sel),
    .illegal  (dec_illegal)
  );

  assign old_val  = sel_q.m ? mscratch : sscratch;
  assign suppress = (op_q != OP_RW) && no_write_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (req_valid) state_nxt = dec_illegal ? ST_RESP : ST_READ;
      ST_READ:  state_nxt = suppress ? ST_RESP : ST_WRITE;
      ST_WRITE: state_nxt = ST_RESP;
      ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= '0;
      op_q       <= '0;
      wdata_q    <= '0;
      no_write_q <= 1'b0;
      illegal_q  <= 1'b0;
      new_q      <= '0;
      rdata_q    <= '0;
    end else if (state == ST_IDLE && req_valid) begin
      sel_q      <= dec_sel;
      op_q       <= req_op;
      wdata_q    <= req_wdata;
      no_write_q <= req_no_write;
      illegal_q  <= dec_illegal;
      rdata_q    <= '0;
    end else if (state == ST_READ) begin
      rdata_q <= old_val;
      unique case (op_q)
        OP_RS:   new_q <= old_val | wdata_q;
        OP_RC:   new_q <= old_val & ~wdata_q;
        default: new_q <= wdata_q;
      endcase
    end
  end

  // Write-port outputs are decoded purely from registered state
  assign req_ready        = (state == ST_IDLE);
  assign rsp_valid        = (state == ST_RESP);
  assign rsp_rdata        = rdata_q;
  assign rsp_illegal      = illegal_q;
  assign csr_write        = (state == ST_WRITE);
  assign data_csr         = csr_write ? new_q : '0;
  assign mrw_mscratch_sel = csr_write && sel_q.m;
  assign srw_sscratch_sel = csr_write && sel_q.s;

endmodule
